// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: buffers a host payload, then sends header, payload and parity; start-to-done is 2*len+3 cycles minimum.
// Router busy freezes the byte on data_out; the host side is stalled by pld_ready, which is high only while loading.
module router_pkt_tx #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic       pld_valid,
  input  logic [7:0] pld_data,
  output logic       pld_ready,
  input  logic       busy,
  input  logic       err,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_busy,
  output logic       done,
  output logic       reject,
  output logic       err_seen
);

  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic [7:0] hdr;
  logic [7:0] par;
  logic [5:0] wr;
  logic [5:0] rd;
  logic [3:0] gap_cnt;
  logic [5:0] last;
  logic [7:0] pld_buf [64];

  // The header carries the payload length in its upper six bits.
  assign last = hdr[7:2] - 6'd1;

  always_ff @(posedge clock) begin
    if (state == LOAD && pld_valid) begin
      pld_buf[wr] <= pld_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      hdr       <= '0;
      par       <= '0;
      wr        <= '0;
      rd        <= '0;
      gap_cnt   <= '0;
      pld_ready <= 1'b0;
      pkt_valid <= 1'b0;
      data_out  <= '0;
      tx_busy   <= 1'b0;
      done      <= 1'b0;
      reject    <= 1'b0;
      err_seen  <= 1'b0;
    end else begin
      done   <= 1'b0;
      reject <= 1'b0;
      if (state != IDLE && state != LOAD && err) begin
        err_seen <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (dest != 2'd3 && len != 6'd0) begin
              hdr       <= {len, dest};
              par       <= {len, dest};
              wr        <= '0;
              rd        <= '0;
              err_seen  <= 1'b0;
              pld_ready <= 1'b1;
              tx_busy   <= 1'b1;
              state     <= LOAD;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (pld_valid) begin
            par <= par ^ pld_data;
            wr  <= wr + 6'd1;
            if (wr == last) begin
              state     <= HEADER;
              pld_ready <= 1'b0;
              pkt_valid <= 1'b1;
              data_out  <= hdr;
            end
          end
        end
        HEADER: begin
          if (!busy) begin
            state    <= PAYLOAD;
            rd       <= '0;
            data_out <= pld_buf[0];
          end
        end
        PAYLOAD: begin
          // Prefetch the next byte so data_out stays a plain register.
          if (!busy) begin
            if (rd == last) begin
              state     <= PARITY;
              pkt_valid <= 1'b0;
              data_out  <= par;
            end else begin
              rd       <= rd + 6'd1;
              data_out <= pld_buf[rd + 6'd1];
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            done    <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
